// File: rtl/icache_pkg.sv
// Shared types and widths for the instruction-cache miss/prefetch controller.
// A cache line number is {tag, idx}; byte address = {line, 3'b000}.
package icache_pkg;

    localparam int IDX_W     = 4;
    localparam int TAG_W     = 9;
    localparam int LINE_W    = 13;
    localparam int MEM_TAG_W = 4;
    localparam int PF_CNT_W  = 8;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_cmd_t;

    typedef enum logic {
        PF_IDLE   = 1'b0,
        PF_ACTIVE = 1'b1
    } pf_state_t;

    typedef struct packed {
        logic                 valid;
        logic [MEM_TAG_W-1:0] mem_tag;
        logic [IDX_W-1:0]     idx;
        logic [TAG_W-1:0]     tag;
    } mshr_entry_t;

    localparam mshr_entry_t MSHR_EMPTY = '{valid: 1'b0, mem_tag: 4'h0, idx: 4'h0, tag: 9'h000};

    function automatic logic [63:0] line_to_addr(input logic [LINE_W-1:0] line);
        line_to_addr = {48'h0000_0000_0000, line, 3'b000};
    endfunction

endpackage

// File: rtl/icache_mshr_table.sv
// Outstanding-load table: allocates the lowest free slot, frees on a matching
// memory tag, and offers two {idx,tag} lookup ports plus a full flag.
module icache_mshr_table
    import icache_pkg::*;
#(
    parameter int NUM_MSHR = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 alloc_en,
    input  logic [MEM_TAG_W-1:0] alloc_mem_tag,
    input  logic [IDX_W-1:0]     alloc_idx,
    input  logic [TAG_W-1:0]     alloc_tag,
    input  logic [MEM_TAG_W-1:0] fill_mem_tag,
    output logic                 fill_hit,
    output logic [IDX_W-1:0]     fill_idx,
    output logic [TAG_W-1:0]     fill_tag,
    input  logic [IDX_W-1:0]     lookup_a_idx,
    input  logic [TAG_W-1:0]     lookup_a_tag,
    output logic                 lookup_a_hit,
    input  logic [IDX_W-1:0]     lookup_b_idx,
    input  logic [TAG_W-1:0]     lookup_b_tag,
    output logic                 lookup_b_hit,
    output logic                 full
);

    localparam int SLOT_W = (NUM_MSHR > 1) ? $clog2(NUM_MSHR) : 1;

    mshr_entry_t       entries_r [NUM_MSHR];
    logic [SLOT_W-1:0] free_slot_s;
    logic [SLOT_W-1:0] fill_slot_s;
    logic              any_free_s;

    // Slot scans run from the top down so the lowest matching index wins.
    always_comb begin
        any_free_s   = 1'b0;
        free_slot_s  = {SLOT_W{1'b0}};
        fill_hit     = 1'b0;
        fill_slot_s  = {SLOT_W{1'b0}};
        lookup_a_hit = 1'b0;
        lookup_b_hit = 1'b0;
        for (int i = NUM_MSHR - 1; i >= 0; i--) begin
            if (!entries_r[i].valid) begin
                any_free_s  = 1'b1;
                free_slot_s = SLOT_W'(i);
            end else if ((fill_mem_tag != 4'h0) && (entries_r[i].mem_tag == fill_mem_tag)) begin
                fill_hit    = 1'b1;
                fill_slot_s = SLOT_W'(i);
            end else begin
                fill_slot_s = fill_slot_s;
            end
            lookup_a_hit = lookup_a_hit | (entries_r[i].valid &&
                           ({entries_r[i].idx, entries_r[i].tag} == {lookup_a_idx, lookup_a_tag}));
            lookup_b_hit = lookup_b_hit | (entries_r[i].valid &&
                           ({entries_r[i].idx, entries_r[i].tag} == {lookup_b_idx, lookup_b_tag}));
        end
        full     = !any_free_s;
        fill_idx = entries_r[fill_slot_s].idx;
        fill_tag = entries_r[fill_slot_s].tag;
    end

    // Allocation and fill never target the same slot: one is free, the other valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_MSHR; i++) begin
            if (reset) begin
                entries_r[i] <= MSHR_EMPTY;
            end else if (alloc_en && any_free_s && (free_slot_s == SLOT_W'(i))) begin
                entries_r[i] <= '{valid: 1'b1, mem_tag: alloc_mem_tag, idx: alloc_idx, tag: alloc_tag};
            end else if (fill_hit && (fill_slot_s == SLOT_W'(i))) begin
                entries_r[i].valid <= 1'b0;
            end else begin
                entries_r[i] <= entries_r[i];
            end
        end
    end

endmodule

// File: rtl/icache_ctrl.sv
// Instruction-cache miss/prefetch controller: zero-latency hits, demand-miss
// loads with tagged tracking, line fills and a sequential next-line prefetcher.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int NUM_MSHR = 4,
    parameter int PF_DEPTH = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [63:0]          fetch_addr,
    output logic [63:0]          icache_data_out,
    output logic                 icache_valid_out,
    output logic [IDX_W-1:0]     rd1_idx,
    output logic [TAG_W-1:0]     rd1_tag,
    input  logic [63:0]          rd1_data,
    input  logic                 rd1_valid,
    output logic [IDX_W-1:0]     pf_rd_idx,
    output logic [TAG_W-1:0]     pf_rd_tag,
    input  logic                 pf_valid,
    output logic                 wr1_en,
    output logic [IDX_W-1:0]     wr1_idx,
    output logic [TAG_W-1:0]     wr1_tag,
    output logic [63:0]          wr1_data,
    input  logic                 mem_grant,
    output logic [1:0]           proc2mem_command,
    output logic [63:0]          proc2mem_addr,
    input  logic [MEM_TAG_W-1:0] mem2proc_response,
    input  logic [63:0]          mem2proc_data,
    input  logic [MEM_TAG_W-1:0] mem2proc_tag
);

    localparam logic                PF_EN    = (PF_DEPTH != 32'sd0);
    localparam logic [PF_CNT_W-1:0] PF_START = PF_CNT_W'(PF_DEPTH);

    pf_state_t           pf_state_r;
    logic [LINE_W-1:0]   pf_addr_r;
    logic [PF_CNT_W-1:0] pf_count_r;

    logic [LINE_W-1:0] demand_line_s;
    logic [LINE_W-1:0] issue_line_s;
    logic              demand_in_table_s;
    logic              pf_in_table_s;
    logic              table_full_s;
    logic              fill_hit_s;
    logic [IDX_W-1:0]  fill_idx_s;
    logic [TAG_W-1:0]  fill_tag_s;
    logic              demand_miss_s;
    logic              pf_want_s;
    logic              accepted_s;
    logic              issue_demand_s;
    logic              issue_pf_s;
    logic              alloc_en_s;
    logic              unused_s;

    assign demand_line_s    = fetch_addr[15:3];
    assign unused_s         = ^{fetch_addr[63:16], fetch_addr[2:0]};
    assign rd1_idx          = demand_line_s[IDX_W-1:0];
    assign rd1_tag          = demand_line_s[LINE_W-1:IDX_W];
    assign pf_rd_idx        = pf_addr_r[IDX_W-1:0];
    assign pf_rd_tag        = pf_addr_r[LINE_W-1:IDX_W];
    assign icache_data_out  = rd1_data;
    assign icache_valid_out = !reset && fetch_req && rd1_valid;
    assign wr1_en           = !reset && fill_hit_s;
    assign wr1_idx          = fill_idx_s;
    assign wr1_tag          = fill_tag_s;
    assign wr1_data         = mem2proc_data;
    assign proc2mem_command = (issue_demand_s || issue_pf_s) ? MEM_LOAD : MEM_NONE;
    assign proc2mem_addr    = line_to_addr(issue_line_s);

    icache_mshr_table #(
        .NUM_MSHR(NUM_MSHR)
    ) u_mshr (
        .clock        (clock),
        .reset        (reset),
        .alloc_en     (alloc_en_s),
        .alloc_mem_tag(mem2proc_response),
        .alloc_idx    (issue_line_s[IDX_W-1:0]),
        .alloc_tag    (issue_line_s[LINE_W-1:IDX_W]),
        .fill_mem_tag (mem2proc_tag),
        .fill_hit     (fill_hit_s),
        .fill_idx     (fill_idx_s),
        .fill_tag     (fill_tag_s),
        .lookup_a_idx (rd1_idx),
        .lookup_a_tag (rd1_tag),
        .lookup_a_hit (demand_in_table_s),
        .lookup_b_idx (pf_rd_idx),
        .lookup_b_tag (pf_rd_tag),
        .lookup_b_hit (pf_in_table_s),
        .full         (table_full_s)
    );

    // Issue arbitration: a demand miss always beats a pending prefetch.
    always_comb begin
        demand_miss_s  = fetch_req && !rd1_valid && !demand_in_table_s;
        pf_want_s      = (pf_state_r == PF_ACTIVE) && !pf_valid && !pf_in_table_s;
        accepted_s     = (mem2proc_response != 4'h0);
        issue_demand_s = 1'b0;
        issue_pf_s     = 1'b0;
        issue_line_s   = pf_addr_r;
        if (demand_miss_s) begin
            issue_line_s = demand_line_s;
        end else begin
            issue_line_s = pf_addr_r;
        end
        if (reset || !mem_grant || table_full_s) begin
            issue_demand_s = 1'b0;
            issue_pf_s     = 1'b0;
        end else if (demand_miss_s) begin
            issue_demand_s = 1'b1;
        end else if (pf_want_s) begin
            issue_pf_s = 1'b1;
        end else begin
            issue_pf_s = 1'b0;
        end
        alloc_en_s = (issue_demand_s || issue_pf_s) && accepted_s;
    end

    // Prefetch walker; a line already present or already pending is skipped.
    always_ff @(posedge clock) begin
        if (reset) begin
            pf_state_r <= PF_IDLE;
            pf_addr_r  <= 13'h0000;
            pf_count_r <= 8'd0;
        end else if (issue_demand_s && accepted_s && PF_EN) begin
            pf_state_r <= PF_ACTIVE;
            pf_addr_r  <= demand_line_s + 13'd1;
            pf_count_r <= PF_START;
        end else begin
            case (pf_state_r)
                PF_IDLE: begin
                    pf_state_r <= PF_IDLE;
                end
                PF_ACTIVE: begin
                    if (!pf_want_s || (issue_pf_s && accepted_s)) begin
                        pf_addr_r  <= pf_addr_r + 13'd1;
                        pf_count_r <= pf_count_r - 8'd1;
                        if (pf_count_r <= 8'd1) begin
                            pf_state_r <= PF_IDLE;
                        end else begin
                            pf_state_r <= PF_ACTIVE;
                        end
                    end else begin
                        pf_state_r <= PF_ACTIVE;
                    end
                end
                default: begin
                    pf_state_r <= PF_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl: cold miss, prefetch, refusal, full table,
// reset with loads outstanding and prefetch address wrap.
module tb_icache_ctrl;

    logic        clock;
    logic        reset;
    logic        fetch_req;
    logic [63:0] fetch_addr;
    logic [63:0] icache_data_out;
    logic        icache_valid_out;
    logic [3:0]  rd1_idx;
    logic [8:0]  rd1_tag;
    logic [63:0] rd1_data;
    logic        rd1_valid;
    logic [3:0]  pf_rd_idx;
    logic [8:0]  pf_rd_tag;
    logic        pf_valid;
    logic        wr1_en;
    logic [3:0]  wr1_idx;
    logic [8:0]  wr1_tag;
    logic [63:0] wr1_data;
    logic        mem_grant;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_addr;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    int total = 0;
    int bad   = 0;

    localparam logic [63:0] LINE_DATA = 64'h1234_5678_9ABC_DEF0;

    icache_ctrl #(.NUM_MSHR(4), .PF_DEPTH(2)) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_req        (fetch_req),
        .fetch_addr       (fetch_addr),
        .icache_data_out  (icache_data_out),
        .icache_valid_out (icache_valid_out),
        .rd1_idx          (rd1_idx),
        .rd1_tag          (rd1_tag),
        .rd1_data         (rd1_data),
        .rd1_valid        (rd1_valid),
        .pf_rd_idx        (pf_rd_idx),
        .pf_rd_tag        (pf_rd_tag),
        .pf_valid         (pf_valid),
        .wr1_en           (wr1_en),
        .wr1_idx          (wr1_idx),
        .wr1_tag          (wr1_tag),
        .wr1_data         (wr1_data),
        .mem_grant        (mem_grant),
        .proc2mem_command (proc2mem_command),
        .proc2mem_addr    (proc2mem_addr),
        .mem2proc_response(mem2proc_response),
        .mem2proc_data    (mem2proc_data),
        .mem2proc_tag     (mem2proc_tag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic drive(input logic rst, input logic req, input logic [63:0] addr, input logic rv,
                         input logic grant, input logic [3:0] resp, input logic [3:0] mtag,
                         input logic pfv);
        @(negedge clock);
        reset             = rst;
        fetch_req         = req;
        fetch_addr        = addr;
        rd1_valid         = rv;
        rd1_data          = LINE_DATA;
        mem_grant         = grant;
        mem2proc_response = resp;
        mem2proc_tag      = mtag;
        mem2proc_data     = {60'hC0D_E000_0000_0000, mtag};
        pf_valid          = pfv;
        #1;
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; fetch_addr = 64'h0; rd1_valid = 1'b0;
        rd1_data = 64'h0; mem_grant = 1'b0; mem2proc_response = 4'h0;
        mem2proc_tag = 4'h0; mem2proc_data = 64'h0; pf_valid = 1'b0;

        // reset holds all outputs quiet even with live inputs
        drive(1'b1, 1'b1, 64'h100, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0);
        check_eq("rst_valid", {63'h0, icache_valid_out}, 64'd0);
        check_eq("rst_cmd", {62'h0, proc2mem_command}, 64'd0);
        check_eq("rst_wr", {63'h0, wr1_en}, 64'd0);
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);

        // cold miss at 0x100, then next-line prefetches
        drive(1'b0, 1'b1, 64'h100, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0);
        check_eq("cold_cmd", {62'h0, proc2mem_command}, 64'd1);
        check_eq("cold_addr", proc2mem_addr, 64'h100);
        check_eq("cold_idx", {60'h0, rd1_idx}, 64'd0);
        check_eq("cold_tag", {55'h0, rd1_tag}, 64'd2);
        drive(1'b0, 1'b1, 64'h100, 1'b0, 1'b1, 4'd5, 4'd0, 1'b0);
        check_eq("pf1_cmd", {62'h0, proc2mem_command}, 64'd1);
        check_eq("pf1_addr", proc2mem_addr, 64'h108);
        check_eq("pf1_idx", {60'h0, pf_rd_idx}, 64'd1);
        drive(1'b0, 1'b1, 64'h100, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0);
        check_eq("pf2_addr", proc2mem_addr, 64'h108 + 64'h8);
        check_eq("pf2_cmd", {62'h0, proc2mem_command}, 64'd1);
        drive(1'b0, 1'b0, 64'h100, 1'b0, 1'b1, 4'd7, 4'd0, 1'b0);
        check_eq("pf_done_cmd", {62'h0, proc2mem_command}, 64'd0);
        drive(1'b0, 1'b1, 64'h100, 1'b0, 1'b1, 4'd7, 4'd3, 1'b0);
        check_eq("fill_cmd", {62'h0, proc2mem_command}, 64'd0);
        check_eq("fill_en", {63'h0, wr1_en}, 64'd1);
        check_eq("fill_idx", {60'h0, wr1_idx}, 64'd0);
        check_eq("fill_tag", {55'h0, wr1_tag}, 64'd2);
        check_eq("fill_data", wr1_data, 64'hC0DE_0000_0000_0003);
        drive(1'b0, 1'b1, 64'h100, 1'b1, 1'b1, 4'd7, 4'd0, 1'b0);
        check_eq("hit_valid", {63'h0, icache_valid_out}, 64'd1);
        check_eq("hit_data", icache_data_out, LINE_DATA);
        check_eq("hit_cmd", {62'h0, proc2mem_command}, 64'd0);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0);
        check_eq("stray_tag_wr", {63'h0, wr1_en}, 64'd0);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 4'd0, 4'd5, 1'b0);
        check_eq("fill5_idx", {60'h0, wr1_idx}, 64'd1);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 4'd0, 4'd6, 1'b0);
        check_eq("fill6_idx", {60'h0, wr1_idx}, 64'd2);

        // memory refuses three times: LOAD held at the same address
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 64'h200, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
            check_eq("refuse_cmd", {62'h0, proc2mem_command}, 64'd1);
            check_eq("refuse_addr", proc2mem_addr, 64'h200);
        end
        drive(1'b0, 1'b1, 64'h200, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0);
        check_eq("accept_addr", proc2mem_addr, 64'h200);
        drive(1'b0, 1'b1, 64'h200, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0);
        check_eq("alloc_then_pf", proc2mem_addr, 64'h208);
        drive(1'b0, 1'b1, 64'h200, 1'b0, 1'b1, 4'd4, 4'd0, 1'b0);
        check_eq("pf_retry_addr", proc2mem_addr, 64'h208);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1);
        check_eq("pf_skip_cmd", {62'h0, proc2mem_command}, 64'd0);
        check_eq("pf_skip_idx", {60'h0, pf_rd_idx}, 64'd2);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0);
        check_eq("pf_idle_cmd", {62'h0, proc2mem_command}, 64'd0);

        // fill the table, then a new miss waits for a fill
        drive(1'b0, 1'b1, 64'h300, 1'b0, 1'b1, 4'd8, 4'd0, 1'b0);
        check_eq("full1_addr", proc2mem_addr, 64'h300);
        drive(1'b0, 1'b1, 64'h400, 1'b0, 1'b1, 4'd9, 4'd0, 1'b0);
        check_eq("demand_prio", proc2mem_addr, 64'h400);
        check_eq("demand_prio_cmd", {62'h0, proc2mem_command}, 64'd1);
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b1, 64'h500, 1'b0, 1'b1, 4'd10, 4'd0, 1'b0);
            check_eq("full_cmd", {62'h0, proc2mem_command}, 64'd0);
        end
        drive(1'b0, 1'b1, 64'h500, 1'b0, 1'b1, 4'd10, 4'd2, 1'b0);
        check_eq("full_fill_cmd", {62'h0, proc2mem_command}, 64'd0);
        check_eq("full_fill_en", {63'h0, wr1_en}, 64'd1);
        check_eq("full_fill_tag", {55'h0, wr1_tag}, 64'd4);
        drive(1'b0, 1'b1, 64'h500, 1'b0, 1'b1, 4'd11, 4'd0, 1'b0);
        check_eq("after_fill_cmd", {62'h0, proc2mem_command}, 64'd1);
        check_eq("after_fill_addr", proc2mem_addr, 64'h500);

        // reset with loads outstanding: later responses are ignored
        drive(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 4'd0, 4'd8, 1'b0);
        check_eq("rst2_wr", {63'h0, wr1_en}, 64'd0);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd1, 4'd9, 1'b0);
        check_eq("post_rst_wr9", {63'h0, wr1_en}, 64'd0);
        check_eq("post_rst_cmd", {62'h0, proc2mem_command}, 64'd0);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd1, 4'd8, 1'b0);
        check_eq("post_rst_wr8", {63'h0, wr1_en}, 64'd0);

        // prefetch line number wraps from 0x1FFF to 0x0000
        drive(1'b0, 1'b1, 64'hFFF8, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0);
        check_eq("wrap_addr", proc2mem_addr, 64'hFFF8);
        check_eq("wrap_idx", {60'h0, rd1_idx}, 64'hF);
        check_eq("wrap_tag", {55'h0, rd1_tag}, 64'h1FF);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b1);
        check_eq("wrap_skip_cmd", {62'h0, proc2mem_command}, 64'd0);
        check_eq("wrap_pf_line", {51'h0, pf_rd_tag, pf_rd_idx}, 64'd0);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd2, 4'd0, 1'b0);
        check_eq("wrap_pf_cmd", {62'h0, proc2mem_command}, 64'd1);
        check_eq("wrap_pf_addr", proc2mem_addr, 64'h0008);
        drive(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd3, 4'd0, 1'b0);
        check_eq("wrap_done_cmd", {62'h0, proc2mem_command}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
